// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
// Adds timeout_err when SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN is defined.
interface switch_allocator_if #(
  parameter int NUM_PORTS = 7,
  parameter int SEL_W     = $clog2(NUM_PORTS)
);
  // Handshake: input i's flit moves only in a cycle where grant[i]=1. Until then,
  // req_valid/req_outport/req_tail stay stable. xbar_sel[o] is meaningful only while
  // xbar_valid[o]=1. out_ready[o] is the downstream ready for output o.
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0][SEL_W-1:0] req_outport;
  logic [NUM_PORTS-1:0]            req_tail;
  logic [NUM_PORTS-1:0]            out_ready;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_PORTS-1:0]            xbar_valid;
  logic [NUM_PORTS-1:0][SEL_W-1:0] xbar_sel;
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
  logic [NUM_PORTS-1:0]            timeout_err;

  modport master (output req_valid, req_outport, req_tail, out_ready,
                  input  grant, xbar_valid, xbar_sel, timeout_err);
  modport slave  (input  req_valid, req_outport, req_tail, out_ready,
                  output grant, xbar_valid, xbar_sel, timeout_err);
`else
  modport master (output req_valid, req_outport, req_tail, out_ready,
                  input  grant, xbar_valid, xbar_sel);
  modport slave  (input  req_valid, req_outport, req_tail, out_ready,
                  output grant, xbar_valid, xbar_sel);
`endif
endinterface

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin pick in IDLE, lock to the packet until its tail.
// Optional lock timeout is enabled by defining SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN.
module switch_allocator #(
  parameter int NUM_PORTS = 7,
  parameter int SEL_W     = $clog2(NUM_PORTS)
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_allocator_if.slave    sa,
  output logic [NUM_PORTS-1:0] dbg_locked_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q [NUM_PORTS];
  state_e           state_d [NUM_PORTS];
  logic [SEL_W-1:0] owner_q [NUM_PORTS];
  logic [SEL_W-1:0] owner_d [NUM_PORTS];
  logic [SEL_W-1:0] rr_q    [NUM_PORTS];
  logic [SEL_W-1:0] rr_d    [NUM_PORTS];
  logic [SEL_W-1:0] sel_q   [NUM_PORTS];
  logic [SEL_W-1:0] src     [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] grant_c;
  logic                 found;
  int                   idx;

`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] err_q;
  logic [NUM_PORTS-1:0] err_d;
  assign sa.timeout_err = err_q;
`endif

  always_comb begin : cand_comb
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = sa.req_valid[i] && (sa.req_outport[i] == SEL_W'(o));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= SEL_W'(NUM_PORTS - 1);
        sel_q[o]   <= '0;
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
        cnt_q[o]   <= '0;
`endif
      end
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
      err_q <= '0;
`endif
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        if (xfer[o]) sel_q[o] <= src[o];
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
        cnt_q[o]   <= cnt_d[o];
`endif
      end
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
      err_q <= err_d;
`endif
    end
  end

  always_comb begin : next_state_comb
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
    err_d = '0;
`endif
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
      cnt_d[o]   = cnt_q[o];
`endif
      case (state_q[o])
        IDLE: begin
          if (xfer[o]) begin
            rr_d[o] = src[o];
            if (!sa.req_tail[src[o]]) begin
              state_d[o] = LOCKED;
              owner_d[o] = src[o];
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
              cnt_d[o]   = '0;
`endif
            end
          end
        end
        LOCKED: begin
          if (xfer[o]) begin
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
            cnt_d[o] = '0;
`endif
            if (sa.req_tail[owner_q[o]]) state_d[o] = IDLE;
          end
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
          // A stalled owner gives up the output after TIMEOUT_CYCLES idle locked cycles.
          else if (cnt_q[o] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d[o] = IDLE;
            cnt_d[o]   = '0;
            err_d[o]   = 1'b1;
          end else begin
            cnt_d[o] = cnt_q[o] + 1'b1;
          end
`endif
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_comb begin : output_comb
    xfer    = '0;
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      src[o] = owner_q[o];
      found  = 1'b0;
      if (state_q[o] == IDLE) begin
        // Scan starts just past the last winner so it ends up lowest priority.
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = int'(rr_q[o]) + k;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (!found && cand[o][idx]) begin
            found  = 1'b1;
            src[o] = SEL_W'(idx);
          end
        end
        xfer[o] = found && sa.out_ready[o];
      end else begin
        xfer[o] = cand[o][owner_q[o]] && sa.out_ready[o];
      end
      if (xfer[o]) grant_c[src[o]] = 1'b1;
    end

    sa.grant      = rst ? '0 : grant_c;
    sa.xbar_valid = rst ? '0 : xfer;
    for (int o = 0; o < NUM_PORTS; o++) begin
      sa.xbar_sel[o]  = rst ? '0 : (xfer[o] ? src[o] : sel_q[o]);
      dbg_locked_o[o] = (state_q[o] == LOCKED);
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed-vector bench for switch_allocator; timeout scenario runs when
// SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN is defined.
module tb_switch_allocator;
  localparam int NP = 7;
  localparam int SW = 3;
  localparam int EAST = 3, WEST = 4, UP = 5, DOWN = 6;

  logic          clk;
  logic          rst;
  logic [NP-1:0] dbg_locked;
  int            n_checks;
  int            n_errors;
  logic [31:0]   exp_q[$];

  switch_allocator_if #(.NUM_PORTS(NP), .SEL_W(SW)) sa_if ();

  switch_allocator #(
    .NUM_PORTS(NP),
    .SEL_W(SW)
`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sa           (sa_if),
    .dbg_locked_o (dbg_locked)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // driver tasks
  task automatic clear_reqs();
    sa_if.req_valid   = '0;
    sa_if.req_tail    = '0;
    sa_if.req_outport = '0;
    sa_if.out_ready   = '1;
  endtask

  task automatic req(input int i, input int o, input logic tail);
    sa_if.req_valid[i]   = 1'b1;
    sa_if.req_outport[i] = SW'(o);
    sa_if.req_tail[i]    = tail;
  endtask

  task automatic drop(input int i);
    sa_if.req_valid[i] = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int seq[3];
    logic [31:0] e;
    n_checks = 0;
    n_errors = 0;
    seq[0] = 0; seq[1] = 2; seq[2] = 5;

    rst = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(sa_if.grant), 32'h0);
    check("rst_xvalid", 32'(sa_if.xbar_valid), 32'h0);
    check("rst_xsel", 32'(sa_if.xbar_sel), 32'h0);
    check("rst_locked", 32'(dbg_locked), 32'h0);
    rst = 1'b0;

    // round-robin of single-flit packets on EAST
    req(0, EAST, 1'b1); req(2, EAST, 1'b1); req(5, EAST, 1'b1);
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(seq[k % 3]));
    for (int k = 0; k < 6; k++) begin
      sample();
      e = exp_q.pop_front();
      check("rr_grant", 32'(sa_if.grant), 32'(1) << e);
      check("rr_sel", 32'(sa_if.xbar_sel[EAST]), e);
      check("rr_xvalid", 32'(sa_if.xbar_valid), 32'(1) << EAST);
      next_cycle();
    end
    clear_reqs();

    // 4-flit wormhole on UP from input 3, input 1 waits
    req(3, UP, 1'b0);
    sample(); check("wh_head", 32'(sa_if.grant), 32'(1) << 3);
    next_cycle();
    req(1, UP, 1'b1);
    for (int k = 0; k < 3; k++) begin
      req(3, UP, k == 2);
      sample();
      check("wh_body", 32'(sa_if.grant), 32'(1) << 3);
      check("wh_sel", 32'(sa_if.xbar_sel[UP]), 32'd3);
      check("wh_locked", 32'(dbg_locked[UP]), 32'd1);
      next_cycle();
    end
    drop(3);
    sample();
    check("wh_next", 32'(sa_if.grant), 32'(1) << 1);
    check("wh_next_sel", 32'(sa_if.xbar_sel[UP]), 32'd1);
    check("wh_unlocked", 32'(dbg_locked[UP]), 32'd0);
    next_cycle();
    clear_reqs();

    // locked UP with backpressure and owner bubbles; input 0 blocked meanwhile
    req(4, UP, 1'b0);
    sample(); check("bp_head", 32'(sa_if.grant), 32'(1) << 4);
    next_cycle();
    req(0, UP, 1'b1);
    sa_if.out_ready[UP] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("bp_stall_grant", 32'(sa_if.grant), 32'h0);
      check("bp_stall_xvalid", 32'(sa_if.xbar_valid), 32'h0);
      check("bp_sel_hold", 32'(sa_if.xbar_sel[UP]), 32'd4);
      check("bp_locked", 32'(dbg_locked[UP]), 32'd1);
      next_cycle();
    end
    sa_if.out_ready[UP] = 1'b1;
    drop(4);
    for (int k = 0; k < 2; k++) begin
      sample();
      check("bubble_grant", 32'(sa_if.grant), 32'h0);
      check("bubble_locked", 32'(dbg_locked[UP]), 32'd1);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      req(4, UP, k == 2);
      sample();
      check("bp_resume", 32'(sa_if.grant), 32'(1) << 4);
      next_cycle();
    end
    drop(4);
    sample();
    check("bp_after", 32'(sa_if.grant), 32'(1) << 0);
    check("bp_after_locked", 32'(dbg_locked[UP]), 32'd0);
    next_cycle();
    clear_reqs();

    // every output served in the same cycle
    for (int i = 0; i < NP; i++) req(i, (i + 1) % NP, 1'b1);
    sample();
    check("all_grant", 32'(sa_if.grant), 32'h7f);
    check("all_xvalid", 32'(sa_if.xbar_valid), 32'h7f);
    for (int o = 0; o < NP; o++) check("all_sel", 32'(sa_if.xbar_sel[o]), 32'((o + NP - 1) % NP));
    next_cycle();
    clear_reqs();

    // reset in the middle of a 5-flit packet on WEST
    req(2, WEST, 1'b0);
    sample(); check("mid_head", 32'(sa_if.grant), 32'(1) << 2);
    next_cycle();
    sample(); check("mid_body", 32'(sa_if.grant), 32'(1) << 2);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(sa_if.grant), 32'h0);
    check("mid_rst_xvalid", 32'(sa_if.xbar_valid), 32'h0);
    check("mid_rst_xsel", 32'(sa_if.xbar_sel), 32'h0);
    check("mid_rst_locked", 32'(dbg_locked), 32'h0);
    next_cycle();
    rst = 1'b0;
    clear_reqs();
    req(0, WEST, 1'b1); req(6, WEST, 1'b1);
    sample();
    check("post_rst_grant", 32'(sa_if.grant), 32'(1) << 0);
    check("post_rst_sel", 32'(sa_if.xbar_sel[WEST]), 32'd0);
    check("post_rst_locked", 32'(dbg_locked[WEST]), 32'd0);
    next_cycle();
    drop(0);
    sample();
    check("post_rst_second", 32'(sa_if.grant), 32'(1) << 6);
    next_cycle();
    clear_reqs();

`ifdef SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN
    // owner stalls after its head on DOWN; lock released after 8 idle cycles
    req(5, DOWN, 1'b0);
    sample(); check("to_head", 32'(sa_if.grant), 32'(1) << 5);
    next_cycle();
    drop(5);
    req(2, DOWN, 1'b1);
    for (int s = 1; s <= 8; s++) begin
      sample();
      check("to_stall_grant", 32'(sa_if.grant), 32'h0);
      check("to_stall_err", 32'(sa_if.timeout_err), 32'h0);
      next_cycle();
    end
    sample();
    check("to_err_pulse", 32'(sa_if.timeout_err), 32'(1) << DOWN);
    check("to_competitor", 32'(sa_if.grant), 32'(1) << 2);
    next_cycle();
    drop(2);
    sample();
    check("to_err_clear", 32'(sa_if.timeout_err), 32'h0);
    next_cycle();
    clear_reqs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output wormhole switch allocator for the 3D mesh router. It is the consumer of the route computation units' outport decisions.
- Each of the NUM_PORTS input buffers presents its head flit's computed outport. For each output, the allocator picks one input by round-robin and locks that output to the winning packet until its tail flit transfers.
- It drives the crossbar selects and the per-input grants that pop the input buffers.

Parameters:
- NUM_PORTS, 7, number of router ports (LOCAL, NORTH, SOUTH, EAST, WEST, UP, DOWN). Inputs and outputs are indexed by port_t numeric value, 0..NUM_PORTS-1.
- SEL_W, $clog2(NUM_PORTS), width of the crossbar select.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  [NUM_PORTS]  input i has a flit available.
- req_outport  input  port_t[NUM_PORTS]  route of input i's current packet. It is constant for every flit of a packet.
- req_tail  input  [NUM_PORTS]  input i's current flit is the tail. A single-flit packet has head=tail.
- out_ready  input  [NUM_PORTS]  downstream of output o can accept a flit this cycle.
- grant  output  [NUM_PORTS]  input i's flit transfers this cycle; the input buffer pops.
- xbar_valid  output  [NUM_PORTS]  output o carries a flit this cycle.
- xbar_sel  output  [SEL_W][NUM_PORTS]  input index driving output o.

Behaviour:
- Each output o has its own FSM: IDLE or LOCKED. It also holds an owner register (SEL_W bits) and a round-robin pointer rr_ptr (SEL_W bits).
- Candidate set for output o: inputs i with req_valid[i] && req_outport[i]==o.
- Grants are combinational from the registered state plus the current inputs (zero-cycle latency). State updates at the clock edge.

IDLE behaviour (output o):
- When out_ready[o]=1 and at least one candidate exists, the winner is the first candidate found scanning i = rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
- On a win: grant[winner]=1, xbar_valid[o]=1, xbar_sel[o]=winner. At the edge, rr_ptr <= winner.
- If the winner's flit is not a tail, the FSM goes to LOCKED with owner <= winner.
- If the winner's flit is a tail (single-flit packet), the FSM stays IDLE.
- When out_ready[o]=0 or no candidate exists: no grant, xbar_valid[o]=0, and rr_ptr is unchanged.

LOCKED behaviour (output o):
- Only the owner is served; all other candidates are blocked.
- Transfer when req_valid[owner] && req_outport[owner]==o && out_ready[o]. On transfer: grant[owner]=1, xbar_valid[o]=1, xbar_sel[o]=owner.
- A transfer with req_tail[owner]=1 returns the FSM to IDLE at the edge.
- An owner bubble (req_valid=0) holds LOCKED with no transfer.

Cross-output and general rules:
- Each input requests exactly one output, so grant is one-hot per input by construction. Every output allocates independently, and all NUM_PORTS outputs can transfer in the same cycle.
- xbar_sel[o] holds its last value when xbar_valid[o]=0. Consumers must ignore it in that case.
- Backpressure: a flit is transferred only in a cycle where its grant=1. The input must hold valid/outport/tail stable until granted.

Reset (asynchronous, any time, including mid-packet):
- All FSMs go to IDLE, owner=0, rr_ptr=NUM_PORTS-1, so input 0 has first priority.
- All outputs (grant, xbar_valid, xbar_sel) read 0 while rst is asserted.
- Packets in flight are dropped from allocator state. Input buffers are flushed by their own reset.

Optional Feature:
- Macro: SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYCLES (default 64) and output timeout_err [NUM_PORTS].
- Each LOCKED output keeps a stall counter. The counter:
  - clears on any transfer or on entry to LOCKED;
  - increments on each LOCKED cycle with no transfer.
- When the counter reaches TIMEOUT_CYCLES-1 without a transfer, the output is forced to IDLE at the next edge and timeout_err[o] pulses high for exactly 1 cycle.
- Counters and timeout_err reset to 0.
- Undefined: no counter, no port, no parameter; LOCKED persists indefinitely until the tail transfers.

Test Plan:
- After reset, inputs 0, 2 and 5 each send a single-flit packet to output EAST every cycle with out_ready all 1 -> EAST grants rotate 0, 2, 5, 0, 2, 5. xbar_sel[EAST] follows; exactly one grant per cycle.
- Input 3 sends a 4-flit packet (head, body, body, tail) to UP while input 1 also requests UP -> input 3 is granted for 4 consecutive cycles. Input 1 is granted on cycle 5 only.
- While locked, out_ready[UP]=0 for 3 cycles and the owner's req_valid drops for 2 cycles -> no grants in those cycles, LOCKED is held, and the remaining flits complete afterward in order.
- Inputs 0..6 each target a distinct output, all ready -> all 7 grants are asserted in the same cycle, with xbar_sel[o] equal to the correct source for every output.
- rst is asserted for 1 cycle in the middle of a 5-flit packet on WEST -> outputs go to 0 immediately, WEST is IDLE afterward, and the first post-reset arbitration favours input 0.
- With SWITCH_ALLOCATOR_LOCK_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, the owner stalls after its head flit -> timeout_err[o] pulses on the correct cycle, and a competing input is granted on the next cycle.
